rst_seq_ctrl: RTL

//  Ordered reset-release sequencer for the shell. Holds N downstream stage resets

---
 rtl/rst_seq_pkg.sv | 24 ++
 rtl/rst_seq_cnt.sv | 28 ++
 rtl/rst_seq_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the ordered reset-release sequencer.
package rst_seq_pkg;

    localparam int MAX_STAGES = 16;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_WAIT_ACK,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    // One counter covers every timed state, so it is sized for the longest interval.
    function automatic int cnt_width(input int hold, input int gap, input int timeout);
        int m;
        m = hold;
        if (gap > m) m = gap;
        if (timeout > m) m = timeout;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module rst_seq_cnt #(
    parameter int W       = 10,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= W'(RST_VAL);
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Ordered reset-release sequencer: holds all stage resets, releases them lowest
// index first with ack handshakes and fixed gaps, then monitors acks.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int                  N_STAGES    = 4,
    parameter int                  HOLD_CYCLES = 16,
    parameter int                  STAGE_GAP   = 8,
    parameter int                  ACK_TIMEOUT = 1024,
    parameter logic [N_STAGES-1:0] ACK_MASK    = '1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        soft_rst_req,
    input  logic [N_STAGES-1:0]         stage_ack,
    output logic [N_STAGES-1:0]         stage_rst,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [$clog2(N_STAGES):0]   err_stage
);

    localparam int CW   = cnt_width(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT);
    localparam int IDXW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int ESW  = $clog2(N_STAGES) + 1;

    state_t              state, next_state;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [N_STAGES-1:0] stage_rst_d;
    logic [ESW-1:0]      err_stage_d;
    logic                busy_d, done_d, err_d;
    logic                cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]       cnt_val;
    logic [N_STAGES-1:0] missing;
    logic [ESW-1:0]      low_idx;

    // Reset pattern with stages [0, k) released and [k, N) held.
    function automatic logic [N_STAGES-1:0] rst_from(input int k);
        logic [N_STAGES-1:0] r;
        for (int j = 0; j < N_STAGES; j++) r[j] = (j >= k);
        return r;
    endfunction

    rst_seq_cnt #(
        .W       (CW),
        .RST_VAL (HOLD_CYCLES - 1)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign missing = ACK_MASK & ~stage_ack;

    always_comb begin
        low_idx = '0;
        for (int j = N_STAGES - 1; j >= 0; j--) begin
            if (missing[j]) low_idx = ESW'(j);
        end
    end

    // Output registers take the value implied by the next state, so the release
    // of a stage lands on the same edge that enters RELEASE.
    always_comb begin
        next_state  = state;
        idx_d       = idx_q;
        stage_rst_d = stage_rst;
        err_stage_d = err_stage;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_dec     = 1'b0;

        if (soft_rst_req) begin
            next_state  = ST_HOLD;
            idx_d       = '0;
            stage_rst_d = '1;
            err_stage_d = '0;
            cnt_load    = 1'b1;
            cnt_val     = CW'(HOLD_CYCLES - 1);
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt_zero) begin
                        next_state  = ST_RELEASE;
                        idx_d       = '0;
                        stage_rst_d = rst_from(1);
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    cnt_load = 1'b1;
                    if (ACK_MASK[idx_q]) begin
                        next_state = ST_WAIT_ACK;
                        cnt_val    = CW'(ACK_TIMEOUT - 1);
                    end else begin
                        next_state = ST_GAP;
                        cnt_val    = CW'(STAGE_GAP - 1);
                    end
                end
                ST_WAIT_ACK: begin
                    if (stage_ack[idx_q]) begin
                        next_state = ST_GAP;
                        cnt_load   = 1'b1;
                        cnt_val    = CW'(STAGE_GAP - 1);
                    end else if (cnt_zero) begin
                        next_state  = ST_ERROR;
                        err_stage_d = ESW'(idx_q);
                        stage_rst_d = rst_from(int'(idx_q));
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        if (int'(idx_q) == N_STAGES - 1) begin
                            next_state = ST_DONE;
                        end else begin
                            next_state  = ST_RELEASE;
                            idx_d       = idx_q + 1'b1;
                            stage_rst_d = rst_from(int'(idx_q) + 2);
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (|missing) begin
                        next_state  = ST_ERROR;
                        err_stage_d = low_idx;
                        stage_rst_d = rst_from(int'(low_idx));
                    end
                end
                ST_ERROR: begin
                    next_state = ST_ERROR;
                end
                default: begin
                    next_state = ST_ERROR;
                end
            endcase
        end

        busy_d = (next_state == ST_HOLD) || (next_state == ST_RELEASE) ||
                 (next_state == ST_WAIT_ACK) || (next_state == ST_GAP);
        done_d = (next_state == ST_DONE);
        err_d  = (next_state == ST_ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_HOLD;
            idx_q     <= '0;
            stage_rst <= '1;
            err_stage <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= next_state;
            idx_q     <= idx_d;
            stage_rst <= stage_rst_d;
            err_stage <= err_stage_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule
